// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU: one shared 1-bit slice walks the operands LSB first,
// with an extra FIX cycle so set-less-than can patch result[0] from sign and overflow.
module serial_alu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_src1, r_src2, r_result;
  logic             r_ainv, r_binv, r_carry, r_sign;
  logic [1:0]       r_op;
  logic [IW-1:0]    r_idx;
  logic             r_busy, r_done, r_zero, r_cout, r_overflow;

  logic             w_a, w_b, w_sum, w_cnext, w_bit, w_ovf;
  logic [WIDTH-1:0] w_res_run, w_res_fix;

  assign w_a     = r_ainv ^ r_src1[r_idx];
  assign w_b     = r_binv ^ r_src2[r_idx];
  assign w_sum   = w_a ^ w_b ^ r_carry;
  assign w_cnext = (w_a & w_b) | ((w_a ^ w_b) & r_carry);
  // Overflow is carry-into-MSB xor carry-out, only meaningful on the adder ops.
  assign w_ovf   = r_op[1] & (r_carry ^ w_cnext);

  always_comb begin
    unique case (r_op)
      2'b00:   w_bit = w_a & w_b;
      2'b01:   w_bit = w_a | w_b;
      2'b10:   w_bit = w_sum;
      default: w_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_res_run        = r_result;
    w_res_run[r_idx] = w_bit;
  end

  always_comb begin
    w_res_fix    = r_result;
    w_res_fix[0] = r_sign ^ r_overflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_src1     <= '0;
      r_src2     <= '0;
      r_result   <= '0;
      r_ainv     <= 1'b0;
      r_binv     <= 1'b0;
      r_carry    <= 1'b0;
      r_sign     <= 1'b0;
      r_op       <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_zero     <= 1'b0;
      r_cout     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src1  <= src1;
            r_src2  <= src2;
            r_ainv  <= ALU_control[3];
            r_binv  <= ALU_control[2];
            r_op    <= ALU_control[1:0];
            r_carry <= ALU_control[2];
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result <= w_res_run;
          r_carry  <= w_cnext;
          r_idx    <= r_idx + IW'(1);
          if (r_idx == LAST) begin
            r_sign     <= w_sum;
            r_cout     <= w_cnext;
            r_overflow <= w_ovf;
            if (r_op == 2'b11) begin
              r_state <= S_FIX;
            end else begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_zero  <= (w_res_run == '0);
              r_state <= S_DONE;
            end
          end
        end
        S_FIX: begin
          r_result <= w_res_fix;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_zero   <= (w_res_fix == '0);
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign zero     = r_zero;
  assign cout     = r_cout;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_alu_ctrl;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         co;
    logic         ov;
    int           dcyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] src1 = '0, src2 = '0;
  logic [3:0]   alu = '0;
  logic         busy, done, zero, cout, overflow;
  logic [W-1:0] result;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t last;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src1(src1), .src2(src2),
    .ALU_control(alu), .busy(busy), .done(done), .result(result),
    .zero(zero), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ALU semantics as whole-word arithmetic on the (optionally inverted) operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl);
    exp_t         e;
    logic [W-1:0] aa, bb, s;
    logic [W:0]   full;
    logic         sovf;
    aa   = ctl[3] ? ~a : a;
    bb   = ctl[2] ? ~b : b;
    full = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, ctl[2]};
    s    = full[W-1:0];
    sovf = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
    case (ctl[1:0])
      2'b00:   e.res = aa & bb;
      2'b01:   e.res = aa | bb;
      2'b10:   e.res = s;
      default: e.res = {{(W-1){1'b0}}, s[W-1] ^ sovf};
    endcase
    e.co   = full[W];
    e.ov   = ctl[1] ? sovf : 1'b0;
    e.z    = (e.res == '0);
    e.dcyc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic co, input logic ov);
    exp_t e;
    e.res = r; e.z = z; e.co = co; e.ov = ov; e.dcyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result",   64'(result),   64'(e.res));
        chk("zero",     64'(zero),     64'(e.z));
        chk("cout",     64'(cout),     64'(e.co));
        chk("overflow", 64'(overflow), 64'(e.ov));
        chk("done_cycle", 64'(cyc), 64'(e.dcyc));
        chk("busy_in_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || done !== 1'b0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_bad++;
      $display("FAIL idle_timeout: got busy=%0b done=%0b expected idle", busy, done);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctl,
                       input exp_t e, input bit push);
    wait_idle();
    src1 = a; src2 = b; alu = ctl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (push) begin
      e.dcyc = cyc + ((ctl[1:0] == 2'b11) ? W + 1 : W);
      sb.push_back(e);
      last = e;
    end
    src1 = $urandom; src2 = $urandom; alu = 4'($urandom);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, e2;
    logic [W-1:0] a, b;
    logic [3:0]   c;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h7FFFFFFF, 32'h00000001, 4'b0010, mk(32'h80000000, 1'b0, 1'b0, 1'b1), 1'b1);
    issue(32'h00000005, 32'h00000005, 4'b0110, mk(32'h00000000, 1'b1, 1'b1, 1'b0), 1'b1);
    issue(32'hFFFFFFFF, 32'h00000001, 4'b0111, mk(32'h00000001, 1'b0, 1'b1, 1'b0), 1'b1);
    issue(32'h80000000, 32'h00000001, 4'b0111, mk(32'h00000001, 1'b0, 1'b1, 1'b1), 1'b1);
    issue(32'h00000003, 32'h00000002, 4'b0111, mk(32'h00000000, 1'b1, 1'b1, 1'b0), 1'b1);
    issue(32'h0F0F0F0F, 32'h00FF00FF, 4'b1100, mk(32'hF000F000, 1'b0, 1'b1, 1'b0), 1'b1);

    // start held high: one op, then a second accepted only after DONE->IDLE
    wait_idle();
    a = 32'hDEADBEEF; b = 32'h0FF00FF0;
    src1 = a; src2 = b; alu = 4'b0000; start = 1'b1;
    @(posedge clk); #1;
    e  = model(a, b, 4'b0000); e.dcyc = cyc + W;
    e2 = e;                    e2.dcyc = cyc + W + 2 + W;
    sb.push_back(e); sb.push_back(e2);
    last = e2;
    repeat (W + 2) @(posedge clk);
    #1;
    start = 1'b0;

    // reset in the middle of an ADD: outputs clear at once, no done pulse
    issue(32'h0000FFFF, 32'h0000FFFF, 4'b0010, mk('0, 1'b0, 1'b0, 1'b0), 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("pre_abort_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_zero", 64'(zero), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    chk("abort_ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'h00000010, 32'h00000001, 4'b0110, mk(32'h0000000F, 1'b0, 1'b1, 1'b0), 1'b1);

    for (int i = 0; i < 60; i++) begin
      a = pick();
      b = pick();
      c = 4'($urandom_range(0, 15));
      issue(a, b, c, model(a, b, c), 1'b1);
    end

    wait_idle();
    repeat (5) @(posedge clk);
    #1;
    chk("hold_result", 64'(result), 64'(last.res));
    chk("hold_zero", 64'(zero), 64'(last.z));
    chk("hold_cout", 64'(cout), 64'(last.co));
    chk("hold_ovf", 64'(overflow), 64'(last.ov));
    chk("queue_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
